count_threshold_monitor: RTL

Downstream consumer of `counter_wrapper` when that block runs with `WISHBONE_INTERFACE_EN=0`. It takes each per-window count vector (`count_data_o`/`count_valid_o`) and evaluates every channel against a high and a low threshold, with hysteresis and a hold-off of consecutive windows. It drives a per-channel alarm vector and a buffered AXI-Stream-style event stream reporting alarm transitions. Channels are scanned sequentially, one per clock, so that transition events can be serialised into a single FIFO.

---
 rtl/count_threshold_monitor.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/count_threshold_monitor.sv
// count_threshold_monitor
// Watches per-window count vectors and checks each channel against a high and
// a low threshold. Hysteresis and a hold-off of consecutive windows apply to
// every transition. Channels are scanned one per clock, so alarm transitions
// can be serialised into a single first-word-fall-through event FIFO.
// Optional feature macro: COUNT_MONITOR_PEAK_EN adds the per-channel peak
// registers and the peak_o port.
module count_threshold_monitor #(
  parameter int NUM_OF_CHANNELS = 16,
  parameter int COUNT_WIDTH     = 32,
  parameter int HOLD_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  localparam int CW = (NUM_OF_CHANNELS > 1) ? $clog2(NUM_OF_CHANNELS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_OF_CHANNELS*COUNT_WIDTH-1:0] count_data_i,
  input  logic                                   count_valid_i,
  input  logic                                   config_en_i,
  input  logic [COUNT_WIDTH-1:0]                 high_thr_i,
  input  logic [COUNT_WIDTH-1:0]                 low_thr_i,
  input  logic [HOLD_WIDTH-1:0]                  hold_i,
  input  logic                                   clear_i,
  output logic [NUM_OF_CHANNELS-1:0]             alarm_o,
  output logic                                   evt_tvalid_o,
  input  logic                                   evt_tready_i,
  output logic [CW-1:0]                          evt_channel_o,
  output logic                                   evt_rise_o,
  output logic [COUNT_WIDTH-1:0]                 evt_count_o,
  output logic                                   overflow_o,
  output logic                                   missed_o,
  output logic                                   busy_o
`ifdef COUNT_MONITOR_PEAK_EN
  ,
  output logic [NUM_OF_CHANNELS*COUNT_WIDTH-1:0] peak_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + 1 + COUNT_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OF_CHANNELS - 1);

  // A hold of zero behaves like a hold of one.
  function automatic logic [HOLD_WIDTH-1:0] eff_hold(input logic [HOLD_WIDTH-1:0] h);
    return (h == '0) ? HOLD_WIDTH'(1) : h;
  endfunction

  // Run counters stick at their maximum instead of wrapping.
  function automatic logic [HOLD_WIDTH-1:0] sat_inc(input logic [HOLD_WIDTH-1:0] v);
    return (&v) ? v : v + HOLD_WIDTH'(1);
  endfunction

  // FSM and scan index
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;

  // Configuration registers and the per-scan shadow copy
  logic [COUNT_WIDTH-1:0] cfg_high_q, cfg_high_d;
  logic [COUNT_WIDTH-1:0] cfg_low_q, cfg_low_d;
  logic [HOLD_WIDTH-1:0]  cfg_hold_q, cfg_hold_d;
  logic [COUNT_WIDTH-1:0] shd_high_q;
  logic [COUNT_WIDTH-1:0] shd_low_q;
  logic [HOLD_WIDTH-1:0]  shd_hold_q;

  // Captured window and per-channel state
  logic [COUNT_WIDTH-1:0]     cnt_q [NUM_OF_CHANNELS];
  logic [NUM_OF_CHANNELS-1:0] alarm_q;
  logic [HOLD_WIDTH-1:0]      run_q [NUM_OF_CHANNELS];

  // Sticky flags
  logic overflow_q, missed_q;

  // Event FIFO
  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic [EW-1:0] rd_ent;

  // Evaluation of the current channel
  logic                   start;
  logic                   scan;
  logic [COUNT_WIDTH-1:0] cur_cnt;
  logic [HOLD_WIDTH-1:0]  cur_run;
  logic                   cur_alarm;
  logic                   hit;
  logic [HOLD_WIDTH:0]    run_p1;
  logic                   fire;
  logic [HOLD_WIDTH-1:0]  run_nxt;
  logic [EW-1:0]          push_ent;

  assign scan  = (state_q == S_SCAN);
  assign start = (state_q == S_IDLE) && count_valid_i;

  // A config write in the same cycle as a window strobe lands in that scan.
  always_comb begin
    cfg_high_d = cfg_high_q;
    cfg_low_d  = cfg_low_q;
    cfg_hold_d = cfg_hold_q;
    if (config_en_i) begin
      cfg_high_d = high_thr_i;
      cfg_low_d  = low_thr_i;
      cfg_hold_d = hold_i;
    end
  end

  // Next-state logic for the IDLE/SCAN sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (start) begin
      state_d = S_SCAN;
      idx_d   = '0;
    end else if (scan) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + CW'(1);
      end
    end
  end

  // Threshold test, hold-off counting and transition detect for channel idx.
  always_comb begin
    cur_cnt   = cnt_q[idx_q];
    cur_run   = run_q[idx_q];
    cur_alarm = alarm_q[idx_q];
    hit       = cur_alarm ? (cur_cnt <= shd_low_q) : (cur_cnt >= shd_high_q);
    run_p1    = {1'b0, cur_run} + {{HOLD_WIDTH{1'b0}}, 1'b1};
    fire      = scan && hit && (run_p1 >= {1'b0, eff_hold(shd_hold_q)});
    run_nxt   = '0;
    if (hit && !fire) begin
      run_nxt = sat_inc(cur_run);
    end
    push_ent  = {idx_q, ~cur_alarm, cur_cnt};
  end

  // FIFO status; a full FIFO still accepts a push when it pops in the same cycle.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    fifo_pop   = !fifo_empty && evt_tready_i;
    fifo_push  = fire && (!fifo_full || fifo_pop);
    rd_ent     = fifo_mem_q[rd_ptr_q[AW-1:0]];
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Config registers reset to "never alarm": high all-ones, low zero, hold one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_high_q <= '1;
      cfg_low_q  <= '0;
      cfg_hold_q <= HOLD_WIDTH'(1);
    end else begin
      cfg_high_q <= cfg_high_d;
      cfg_low_q  <= cfg_low_d;
      cfg_hold_q <= cfg_hold_d;
    end
  end

  // Window and shadow capture; only read during a scan that follows a capture.
  always_ff @(posedge clk) begin
    if (start) begin
      shd_high_q <= cfg_high_d;
      shd_low_q  <= cfg_low_d;
      shd_hold_q <= cfg_hold_d;
      for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
        cnt_q[i] <= count_data_i[i*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  // Per-channel alarm bit and run counter, one channel updated per scan cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= '0;
      for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
        run_q[i] <= '0;
      end
    end else if (scan) begin
      run_q[idx_q] <= run_nxt;
      if (fire) begin
        alarm_q[idx_q] <= ~cur_alarm;
      end
    end
  end

  // Sticky flags; a set condition beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      if (fire && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end else if (clear_i) begin
        overflow_q <= 1'b0;
      end
      if (count_valid_i && scan) begin
        missed_q <= 1'b1;
      end else if (clear_i) begin
        missed_q <= 1'b0;
      end
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // FIFO storage; stale contents are masked at the outputs while empty.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_ent;
    end
  end

`ifdef COUNT_MONITOR_PEAK_EN
  logic [COUNT_WIDTH-1:0] peak_q [NUM_OF_CHANNELS];

  // Running per-channel maximum; clear beats a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
        peak_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
        peak_q[i] <= '0;
      end
    end else if (scan && (cur_cnt > peak_q[idx_q])) begin
      peak_q[idx_q] <= cur_cnt;
    end
  end

  // Pack the peak registers onto the output bus.
  always_comb begin
    peak_o = '0;
    for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
      peak_o[i*COUNT_WIDTH +: COUNT_WIDTH] = peak_q[i];
    end
  end
`endif

  // Output drive; event fields read as zero while the FIFO is empty.
  always_comb begin
    alarm_o       = alarm_q;
    overflow_o    = overflow_q;
    missed_o      = missed_q;
    busy_o        = scan;
    evt_tvalid_o  = !fifo_empty;
    evt_channel_o = '0;
    evt_rise_o    = 1'b0;
    evt_count_o   = '0;
    if (!fifo_empty) begin
      evt_channel_o = rd_ent[EW-1 -: CW];
      evt_rise_o    = rd_ent[COUNT_WIDTH];
      evt_count_o   = rd_ent[COUNT_WIDTH-1:0];
    end
  end

endmodule
